mem_wb_stage: RTL and testbench

- Memory-access plus write-back stage of the 16-bit pipelined CPU. Sits after EX and fills the MEM/WB slots that the top-level CPU currently leaves empty.
- Accepts EX results, runs load/store transactions on a req/ack data-memory port, and stalls upstream while a transaction is outstanding.
- Drives the register-file write port. This is the writer end of the register file that ID reads.

---
 rtl/mem_wb_stage.sv | 168 ++++++++++++++++
 tb/tb_mem_wb_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory-access and write-back stage: issues load/store on a req/ack data port,
// stalls upstream while an access is outstanding, and drives the register-file write port.
`timescale 1ns/1ps
module mem_wb_stage #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int REG_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] dst,
    input  logic [DATA_W-1:0] st_data,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic              we_in,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic              hlt_in,
    output logic              stall,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_re,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_dst_addr,
    output logic [DATA_W-1:0] rf_w_data,
    output logic              hlt,
    output logic              err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [ADDR_W-1:0]  dm_addr_reg, dm_addr_next;
    logic [DATA_W-1:0]  dm_wdata_reg, dm_wdata_next;
    logic               dm_re_reg, dm_re_next;
    logic               dm_we_reg, dm_we_next;
    logic [REG_W-1:0]   pend_idx_reg, pend_idx_next;
    logic               pend_wr_reg, pend_wr_next;
    logic               rf_we_reg, rf_we_next;
    logic [REG_W-1:0]   rf_dst_addr_reg, rf_dst_addr_next;
    logic [DATA_W-1:0]  rf_w_data_reg, rf_w_data_next;
    logic               hlt_reg, hlt_next;
    logic               err_reg, err_next;

    logic accept;
    logic is_mem;

    // A halted core ignores every incoming instruction.
    assign accept = valid_in & ~hlt_reg;
    assign is_mem = mem_re | mem_we;

    assign stall = ((state_reg == IDLE) & accept & is_mem) | (state_reg == WAIT);

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        dm_addr_next     = dm_addr_reg;
        dm_wdata_next    = dm_wdata_reg;
        dm_re_next       = dm_re_reg;
        dm_we_next       = dm_we_reg;
        pend_idx_next    = pend_idx_reg;
        pend_wr_next     = pend_wr_reg;
        rf_we_next       = 1'b0;
        rf_dst_addr_next = rf_dst_addr_reg;
        rf_w_data_next   = rf_w_data_reg;
        hlt_next         = hlt_reg;
        err_next         = err_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (hlt_in) begin
                        hlt_next = 1'b1;
                    end
                    if (is_mem) begin
                        // Both kinds at once is illegal: only the read is carried out.
                        dm_addr_next  = dst[ADDR_W-1:0];
                        dm_wdata_next = st_data;
                        dm_re_next    = mem_re;
                        dm_we_next    = mem_we & ~mem_re;
                        pend_idx_next = wb_reg;
                        pend_wr_next  = mem_re & we_in & (wb_reg != '0);
                        cnt_next      = '0;
                        state_next    = WAIT;
                        if (mem_re && mem_we) begin
                            err_next = 1'b1;
                        end
                    end else begin
                        rf_we_next       = we_in & (wb_reg != '0);
                        rf_dst_addr_next = wb_reg;
                        rf_w_data_next   = dst;
                    end
                end
            end
            WAIT: begin
                if (dm_ack) begin
                    dm_re_next = 1'b0;
                    dm_we_next = 1'b0;
                    state_next = IDLE;
                    if (pend_wr_reg) begin
                        rf_we_next       = 1'b1;
                        rf_dst_addr_next = pend_idx_reg;
                        rf_w_data_next   = dm_rdata;
                    end
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    // This cycle is the last one allowed: abandon the access.
                    cnt_next   = CNT_W'(TIMEOUT);
                    dm_re_next = 1'b0;
                    dm_we_next = 1'b0;
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            dm_addr_reg     <= '0;
            dm_wdata_reg    <= '0;
            dm_re_reg       <= 1'b0;
            dm_we_reg       <= 1'b0;
            pend_idx_reg    <= '0;
            pend_wr_reg     <= 1'b0;
            rf_we_reg       <= 1'b0;
            rf_dst_addr_reg <= '0;
            rf_w_data_reg   <= '0;
            hlt_reg         <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            dm_addr_reg     <= dm_addr_next;
            dm_wdata_reg    <= dm_wdata_next;
            dm_re_reg       <= dm_re_next;
            dm_we_reg       <= dm_we_next;
            pend_idx_reg    <= pend_idx_next;
            pend_wr_reg     <= pend_wr_next;
            rf_we_reg       <= rf_we_next;
            rf_dst_addr_reg <= rf_dst_addr_next;
            rf_w_data_reg   <= rf_w_data_next;
            hlt_reg         <= hlt_next;
            err_reg         <= err_next;
        end
    end

    assign dm_addr     = dm_addr_reg;
    assign dm_wdata    = dm_wdata_reg;
    assign dm_re       = dm_re_reg;
    assign dm_we       = dm_we_reg;
    assign rf_we       = rf_we_reg;
    assign rf_dst_addr = rf_dst_addr_reg;
    assign rf_w_data   = rf_w_data_reg;
    assign hlt         = hlt_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: the driver queues expected memory requests and
// register writes per instruction; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_mem_wb_stage;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int REG_W   = 4;
    localparam int TIMEOUT = 15;

    localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_ILL = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid_in = 1'b0;
    logic [DATA_W-1:0] dst = '0;
    logic [DATA_W-1:0] st_data = '0;
    logic [REG_W-1:0]  wb_reg = '0;
    logic              we_in = 1'b0;
    logic              mem_re = 1'b0;
    logic              mem_we = 1'b0;
    logic              hlt_in = 1'b0;
    logic              stall;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_re;
    logic              dm_we;
    logic [DATA_W-1:0] dm_rdata = '0;
    logic              dm_ack = 1'b0;
    logic              rf_we;
    logic [REG_W-1:0]  rf_dst_addr;
    logic [DATA_W-1:0] rf_w_data;
    logic              hlt;
    logic              err;

    mem_wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .dst(dst), .st_data(st_data),
        .wb_reg(wb_reg), .we_in(we_in), .mem_re(mem_re), .mem_we(mem_we), .hlt_in(hlt_in),
        .stall(stall), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_re(dm_re), .dm_we(dm_we),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .rf_we(rf_we), .rf_dst_addr(rf_dst_addr),
        .rf_w_data(rf_w_data), .hlt(hlt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [REG_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } rf_exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              is_wr;
        int                dur;
    } mem_exp_t;

    rf_exp_t  rf_q[$];
    mem_exp_t mem_q[$];
    int       n_tests = 0;
    int       n_fail  = 0;
    logic     exp_err = 1'b0;
    logic     exp_hlt = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or a new request.
    rf_exp_t  mon_rf;
    mem_exp_t mon_mem;
    logic     req_seen = 1'b0;
    int       req_dur = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            req_seen = 1'b0;
            req_dur  = 0;
        end else begin
            if (rf_we) begin
                if (rf_q.size() == 0) begin
                    check("rf_we_unexpected", 32'(rf_we), 32'd0);
                end else begin
                    mon_rf = rf_q.pop_front();
                    check("rf_dst_addr", 32'(rf_dst_addr), 32'(mon_rf.idx));
                    check("rf_w_data", 32'(rf_w_data), 32'(mon_rf.data));
                end
            end
            if (dm_re || dm_we) begin
                if (!req_seen) begin
                    if (mem_q.size() == 0) begin
                        check("dm_req_unexpected", 32'({dm_re, dm_we}), 32'd0);
                        mon_mem.addr = dm_addr; mon_mem.wdata = dm_wdata;
                        mon_mem.is_wr = dm_we;  mon_mem.dur = 0;
                    end else begin
                        mon_mem = mem_q.pop_front();
                        check("dm_addr", 32'(dm_addr), 32'(mon_mem.addr));
                        check("dm_kind", 32'({dm_re, dm_we}), mon_mem.is_wr ? 32'd1 : 32'd2);
                        if (mon_mem.is_wr) check("dm_wdata", 32'(dm_wdata), 32'(mon_mem.wdata));
                    end
                    req_seen = 1'b1;
                    req_dur  = 1;
                end else begin
                    req_dur++;
                    check("dm_addr_hold", 32'(dm_addr), 32'(mon_mem.addr));
                    check("dm_kind_hold", 32'({dm_re, dm_we}), mon_mem.is_wr ? 32'd1 : 32'd2);
                end
            end else if (req_seen) begin
                check("dm_req_cycles", 32'(req_dur), 32'(mon_mem.dur));
                req_seen = 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; valid_in = 1'b0; we_in = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
        hlt_in = 1'b0; dm_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_err = 1'b0; exp_hlt = 1'b0;
        rf_q.delete(); mem_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dm_re"}, 32'(dm_re), 32'd0);
        check({tag, "_dm_we"}, 32'(dm_we), 32'd0);
        check({tag, "_dm_addr"}, 32'(dm_addr), 32'd0);
        check({tag, "_dm_wdata"}, 32'(dm_wdata), 32'd0);
        check({tag, "_rf_we"}, 32'(rf_we), 32'd0);
        check({tag, "_rf_dst_addr"}, 32'(rf_dst_addr), 32'd0);
        check({tag, "_rf_w_data"}, 32'(rf_w_data), 32'd0);
        check({tag, "_hlt"}, 32'(hlt), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    // One instruction, entered just after a posedge. lat = WAIT cycle carrying dm_ack; 0 = never.
    task automatic run_op(input int kind, input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] sd,
                          input logic [REG_W-1:0] idx, input logic we, input int lat,
                          input logic [DATA_W-1:0] rd);
        mem_exp_t m;
        rf_exp_t  r;
        int       nwait;
        $display("[TB] op kind=%0d dst=%h st=%h reg=%0d we=%0b lat=%0d rdata=%h",
                 kind, d, sd, idx, we, lat, rd);
        valid_in = 1'b1; dst = d; st_data = sd; wb_reg = idx; we_in = we; hlt_in = 1'b0;
        mem_re = (kind == K_LD || kind == K_ILL);
        mem_we = (kind == K_ST || kind == K_ILL);
        if (kind == K_ALU) begin
            if (we && idx != 0 && !exp_hlt) begin
                r.idx = idx; r.data = d; rf_q.push_back(r);
            end
            @(negedge clk);
            check("stall_alu", 32'(stall), 32'd0);
            check("err_alu", 32'(err), 32'(exp_err));
            @(posedge clk); #1;
            valid_in = 1'b0; we_in = 1'b0;
        end else begin
            m.addr = d; m.wdata = sd; m.is_wr = (kind == K_ST);
            m.dur = (lat == 0) ? TIMEOUT : lat;
            mem_q.push_back(m);
            if (lat != 0 && kind != K_ST && we && idx != 0) begin
                r.idx = idx; r.data = rd; rf_q.push_back(r);
            end
            if (kind == K_ILL || lat == 0) exp_err = 1'b1;
            @(negedge clk);
            check("stall_issue", 32'(stall), 32'd1);
            @(posedge clk); #1;
            valid_in = 1'b0; mem_re = 1'b0; mem_we = 1'b0; we_in = 1'b0;
            nwait = (lat == 0) ? TIMEOUT : lat;
            for (int k = 1; k <= nwait; k++) begin
                dm_ack   = (k == lat);
                dm_rdata = (k == lat) ? rd : DATA_W'($urandom);
                @(negedge clk);
                check("stall_wait", 32'(stall), 32'd1);
                @(posedge clk); #1;
            end
            dm_ack = 1'b0;
            @(negedge clk);
            check("stall_after", 32'(stall), 32'd0);
            check("err_after", 32'(err), 32'(exp_err));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int r;
        int lat;
        do_reset();
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;

        // Directed scenarios.
        run_op(K_ALU, 16'h1234, 16'h0000, 4'd3, 1'b1, 0, 16'h0000);
        run_op(K_ALU, 16'h5678, 16'h0000, 4'd0, 1'b1, 0, 16'h0000);
        run_op(K_LD,  16'h0040, 16'h0000, 4'd5, 1'b1, 3, 16'hBEEF);
        run_op(K_ST,  16'h0010, 16'hA5A5, 4'd6, 1'b1, 1, 16'h0000);
        run_op(K_LD,  16'h0020, 16'h0000, 4'd7, 1'b1, 0, 16'h1111);
        // Late ack two cycles after the timeout must do nothing.
        @(posedge clk); #1;
        dm_ack = 1'b1; dm_rdata = 16'hDEAD;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        @(negedge clk);
        check("late_ack_rf_we", 32'(rf_we), 32'd0);
        check("late_ack_stall", 32'(stall), 32'd0);
        check("late_ack_err", 32'(err), 32'd1);
        @(posedge clk); #1;
        run_op(K_ILL, 16'h0030, 16'h7777, 4'd8, 1'b1, 2, 16'hCAFE);

        // Reset while a load is waiting: no write-back, everything cleared.
        $display("[TB] op load then reset mid-wait");
        valid_in = 1'b1; dst = 16'h0050; wb_reg = 4'd9; we_in = 1'b1; mem_re = 1'b1; mem_we = 1'b0;
        mon_mem.addr = 16'h0050; mon_mem.wdata = '0; mon_mem.is_wr = 1'b0; mon_mem.dur = 99;
        mem_q.push_back(mon_mem);
        @(posedge clk); #1;
        valid_in = 1'b0; mem_re = 1'b0; we_in = 1'b0;
        @(negedge clk);
        check("pre_reset_dm_re", 32'(dm_re), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; exp_err = 1'b0;
        @(negedge clk);
        check_all_zero("midwait");
        @(posedge clk); #1;

        // Randomized instruction stream.
        for (int i = 0; i < 200; i++) begin
            r   = $urandom_range(0, 99);
            lat = $urandom_range(1, 6);
            if (r < 40)      run_op(K_ALU, DATA_W'($urandom), DATA_W'($urandom), REG_W'($urandom), 1'($urandom), 0, '0);
            else if (r < 70) run_op(K_LD,  DATA_W'($urandom), DATA_W'($urandom), REG_W'($urandom), 1'($urandom), lat, DATA_W'($urandom));
            else if (r < 92) run_op(K_ST,  DATA_W'($urandom), DATA_W'($urandom), REG_W'($urandom), 1'($urandom), lat, DATA_W'($urandom));
            else if (r < 96) run_op(K_ILL, DATA_W'($urandom), DATA_W'($urandom), REG_W'($urandom), 1'($urandom), lat, DATA_W'($urandom));
            else             run_op(K_LD,  DATA_W'($urandom), DATA_W'($urandom), REG_W'($urandom), 1'($urandom), 0, DATA_W'($urandom));
        end

        // Halt, then a write that must be ignored.
        $display("[TB] op halt");
        valid_in = 1'b1; hlt_in = 1'b1; we_in = 1'b0; mem_re = 1'b0; mem_we = 1'b0; wb_reg = '0;
        @(negedge clk);
        check("halt_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        valid_in = 1'b0; hlt_in = 1'b0;
        exp_hlt = 1'b1;
        @(negedge clk);
        check("hlt_set", 32'(hlt), 32'd1);
        @(posedge clk); #1;
        run_op(K_ALU, 16'h4321, 16'h0000, 4'd9, 1'b1, 0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hlt_sticky", 32'(hlt), 32'd1);
        check("hlt_no_rf_we", 32'(rf_we), 32'd0);
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        check("hlt_cleared", 32'(hlt), 32'd0);

        check("rf_q_drained", 32'(rf_q.size()), 32'd0);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
